// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and default widths for the generic inter-stage pipeline
// register (pipe_stage_reg) and its storage slot (pipe_slot).
//   pipe_state_t     : EMPTY (M invalid), FULL (M valid), SKID (M and S valid)
//   PIPE_DATA_W_DEF  : default payload width
//   PIPE_CTRL_W_DEF  : default control-bit width
//   PIPE_CNT_W_DEF   : default stall-counter width
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W_DEF = 64;
    localparam int PIPE_CTRL_W_DEF = 8;
    localparam int PIPE_CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of the pipeline register: a W-bit word register with a
// load enable plus an independent valid flop. The valid flop is rewritten
// every cycle from valid_d_i; the word only changes on load_i, so clearing
// the valid bit (flush) leaves the held payload untouched.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (word and valid cleared)
//   load_i    in   capture data_i into the word register
//   data_i    in   W-bit word to capture
//   valid_d_i in   next value of the valid flop
//   data_o    out  registered word
//   valid_o   out  registered valid bit
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_d_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline register placed between core stages. Holds a
// payload and control bits in main slot M; control bits are masked to zero
// whenever the output is not valid so bubbles can never write state.
// Build option: define PIPE_STAGE_SKID_EN to add skid slot S, which lets
// in_ready be a pure register decode (no combinational path from out_ready).
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (highest priority)
//   flush      in   drop held and incoming beats at the next edge
//   in_valid   in   upstream beat present
//   in_ready   out  beat accepted this cycle
//   in_data    in   DATA_W upstream payload
//   in_ctrl    in   CTRL_W upstream control bits
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts beat
//   out_data   out  DATA_W registered payload
//   out_ctrl   out  CTRL_W registered control bits, zero when !out_valid
//   stall_cnt  out  CNT_W saturating count of out_valid && !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DEF,
    parameter int CTRL_W = PIPE_CTRL_W_DEF,
    parameter int CNT_W  = PIPE_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SLOT_W = DATA_W + CTRL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SLOT_W-1:0] in_word;
    logic [SLOT_W-1:0] m_word_d;
    logic [SLOT_W-1:0] m_word_q;
    logic              m_valid_q;
    logic              m_load;
    pipe_state_t       state;
    pipe_state_t       state_d;
    logic              x_fire;
    logic              y_fire;
    logic [CNT_W-1:0]  stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
    logic [SLOT_W-1:0] s_word_q;
    logic              s_valid_q;
    logic              s_load;
    logic              m_from_s;
`endif

    assign in_word = {in_ctrl, in_data};
    assign x_fire  = in_valid && in_ready;
    assign y_fire  = out_valid && out_ready;

    // The slot valid flops are the state register; decode them here.
    always_comb begin
`ifdef PIPE_STAGE_SKID_EN
        if (s_valid_q) begin
            state = SKID;
        end else
`endif
        if (m_valid_q) begin
            state = FULL;
        end else begin
            state = EMPTY;
        end
    end

    always_comb begin
        state_d = state;
        m_load  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        s_load   = 1'b0;
        m_from_s = 1'b0;
`endif
        case (state)
            EMPTY: begin
                if (x_fire) begin
                    state_d = FULL;
                    m_load  = 1'b1;
                end
            end
            FULL: begin
                if (x_fire && y_fire) begin
                    m_load = 1'b1;
                end else if (y_fire) begin
                    state_d = EMPTY;
                end
`ifdef PIPE_STAGE_SKID_EN
                else if (x_fire) begin
                    // Downstream stalled but in_ready was already high:
                    // park the beat in the skid slot.
                    state_d = SKID;
                    s_load  = 1'b1;
                end
`endif
            end
            SKID: begin
`ifdef PIPE_STAGE_SKID_EN
                if (y_fire) begin
                    state_d  = FULL;
                    m_load   = 1'b1;
                    m_from_s = 1'b1;
                end
`endif
            end
            default: state_d = EMPTY;
        endcase

        // Flush only clears valid bits; payload registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
            m_load  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            s_load  = 1'b0;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign m_word_d = m_from_s ? s_word_q : in_word;
    assign in_ready = (state != SKID) && !rst;

    pipe_slot #(.W(SLOT_W)) u_slot_s (
        .clk       (clk),
        .rst       (rst),
        .load_i    (s_load),
        .data_i    (in_word),
        .valid_d_i (state_d == SKID),
        .data_o    (s_word_q),
        .valid_o   (s_valid_q)
    );
`else
    assign m_word_d = in_word;
    assign in_ready = !rst && (!m_valid_q || out_ready);
`endif

    pipe_slot #(.W(SLOT_W)) u_slot_m (
        .clk       (clk),
        .rst       (rst),
        .load_i    (m_load),
        .data_i    (m_word_d),
        .valid_d_i (state_d != EMPTY),
        .data_o    (m_word_q),
        .valid_o   (m_valid_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_word_q[DATA_W-1:0];
    assign out_ctrl  = m_word_q[SLOT_W-1:DATA_W] & {CTRL_W{m_valid_q}};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg (DATA_W=64, CTRL_W=8, CNT_W=3). A monitor
// keeps a scoreboard queue of accepted beats and compares every delivered
// beat; the main sequence checks reset, streaming, back-pressure, the stall
// counter, flush and reset/flush priority. Expectations adapt to whether
// PIPE_STAGE_SKID_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [2:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [71:0] sb_q[$];

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!out_valid) check("bubble_ctrl_zero", {64'd0, out_ctrl}, 72'd0);
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("beat_expected", sb_q.size(), (sb_q.size() == 0) ? 72'd1 : 72'(sb_q.size()));
                if (sb_q.size() != 0) begin
                    logic [71:0] exp_w;
                    exp_w = sb_q.pop_front();
                    $display("beat out ctrl=%0h data=%0h", out_ctrl, out_data);
                    check("beat_payload", {out_ctrl, out_data}, exp_w);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_ctrl, in_data});
            end
        end
    end

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded). Returns at
    // posedge+1 with in_valid dropped.
    task automatic send(input logic [63:0] d, input logic [7:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {71'd0, in_ready}, 72'd1);
        next_drive();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_data = 64'h55; in_ctrl = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", {71'd0, out_valid}, 72'd0);
            check("rst_out_ctrl", {64'd0, out_ctrl}, 72'd0);
            check("rst_out_data", {8'd0, out_data}, 72'd0);
            check("rst_in_ready", {71'd0, in_ready}, 72'd0);
        end
        next_drive();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {71'd0, in_ready}, 72'd1);
        check("post_rst_stall_cnt", {69'd0, stall_cnt}, 72'd0);

        // ---------------- streaming ----------------
        for (int i = 0; i < 16; i++) begin
            next_drive();
            in_valid = 1'b1;
            in_data  = 64'h10 + 64'(i);
            in_ctrl  = 8'(i + 1);
            @(negedge clk);
            check("stream_in_ready", {71'd0, in_ready}, 72'd1);
            if (i > 0) begin
                check("stream_out_valid", {71'd0, out_valid}, 72'd1);
                check("stream_out_data", {8'd0, out_data}, 72'h10 + 72'(i - 1));
            end
        end
        next_drive();
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_data", {8'd0, out_data}, 72'h1F);
        next_drive();
        @(negedge clk);
        check("stream_drained", {71'd0, out_valid}, 72'd0);

        // ---------------- stall counter ----------------
        next_drive();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA1; in_ctrl = 8'hFF;
        @(negedge clk);
        check("stall_load_ready", {71'd0, in_ready}, 72'd1);
        next_drive();
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_start_cnt", {69'd0, stall_cnt}, 72'd0);
        check("full_in_ready", {71'd0, in_ready}, {71'd0, SKID});
        repeat (5) @(negedge clk);
        check("stall_cnt_5", {69'd0, stall_cnt}, 72'd5);
        repeat (10) @(negedge clk);
        check("stall_cnt_sat", {69'd0, stall_cnt}, 72'd7);

        // ---------------- flush with simultaneous input ----------------
        next_drive();
        flush = 1'b1; in_valid = 1'b1; in_data = 64'hB2; in_ctrl = 8'h3C;
        next_drive();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {71'd0, out_valid}, 72'd0);
        check("flush_out_ctrl", {64'd0, out_ctrl}, 72'd0);
        check("flush_payload_kept", {8'd0, out_data}, 72'hA1);
        check("flush_keeps_cnt", {69'd0, stall_cnt}, 72'd7);
        check("flush_in_ready", {71'd0, in_ready}, 72'd1);
        next_drive();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_ghost", {71'd0, out_valid}, 72'd0);
        end

        // ---------------- back-pressure ----------------
        next_drive();
        out_ready = 1'b0;
        send(64'hA1, 8'h11);
`ifdef PIPE_STAGE_SKID_EN
        send(64'hA2, 8'h22);
        @(negedge clk);
        check("skid_in_ready_low", {71'd0, in_ready}, 72'd0);
        check("skid_head_data", {8'd0, out_data}, 72'hA1);
        next_drive();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_first_out", {8'd0, out_data}, 72'hA1);
        @(negedge clk);
        check("bp_second_out", {8'd0, out_data}, 72'hA2);
        check("bp_ready_back", {71'd0, in_ready}, 72'd1);
`else
        in_valid = 1'b1; in_data = 64'hA2; in_ctrl = 8'h22;
        @(negedge clk);
        check("bp_in_ready_low", {71'd0, in_ready}, 72'd0);
        repeat (2) @(negedge clk);
        check("bp_in_ready_hold", {71'd0, in_ready}, 72'd0);
        check("bp_head_data", {8'd0, out_data}, 72'hA1);
        next_drive();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_comb", {71'd0, in_ready}, 72'd1);
        check("bp_first_out", {8'd0, out_data}, 72'hA1);
        next_drive();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_out", {8'd0, out_data}, 72'hA2);
        check("bp_second_valid", {71'd0, out_valid}, 72'd1);
`endif
        @(negedge clk);
        check("bp_drained", {71'd0, out_valid}, 72'd0);
        next_drive();
        check("sb_empty", sb_q.size(), 72'd0);

        // ---------------- rst + flush together with beats held ----------------
        out_ready = 1'b0;
        send(64'hA5, 8'h81);
`ifdef PIPE_STAGE_SKID_EN
        send(64'hA6, 8'h82);
        @(negedge clk);
        check("prio_in_skid", {71'd0, in_ready}, 72'd0);
`else
        @(negedge clk);
        check("prio_in_full", {71'd0, out_valid}, 72'd1);
`endif
        next_drive();
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("prio_rst_in_ready", {71'd0, in_ready}, 72'd0);
        check("prio_cnt_before", {69'd0, stall_cnt}, 72'd7);
        next_drive();
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("prio_out_valid", {71'd0, out_valid}, 72'd0);
        check("prio_out_ctrl", {64'd0, out_ctrl}, 72'd0);
        check("prio_out_data", {8'd0, out_data}, 72'd0);
        check("prio_stall_cnt", {69'd0, stall_cnt}, 72'd0);
        check("prio_in_ready", {71'd0, in_ready}, 72'd1);

        next_drive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
